// File: rtl/ifu_itcm_ctrl_if.sv
// Fetch request/response and loader write channels of the ITCM controller.
interface ifu_itcm_ctrl_if #(
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [PC_SIZE-1:0]    ifu_req_pc;
  logic                  ifu_rsp_valid;
  logic                  ifu_rsp_ready;
  logic [INSTR_SIZE-1:0] ifu_rsp_instr;
  logic                  ifu_rsp_err;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [PC_SIZE-1:0]    ld_addr;
  logic [31:0]           ld_wdata;
  logic [3:0]            ld_wmask;

  modport slave (
    input  ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
           ld_valid, ld_addr, ld_wdata, ld_wmask,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err, ld_ready
  );

  modport master (
    output ifu_req_valid, ifu_req_pc, ifu_rsp_ready,
           ld_valid, ld_addr, ld_wdata, ld_wmask,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_instr, ifu_rsp_err, ld_ready
  );
endinterface

// File: rtl/ifu_itcm_ctrl.sv
// ITCM controller: fetch reads and loader writes to a single-port SRAM with a 2-entry response buffer.
// Optional per-byte even parity on the SRAM word when ITCM_PARITY_EN is defined.
module ifu_itcm_ctrl #(
  parameter int                  ITCM_AW    = 16,
  parameter int                  PC_SIZE    = 32,
  parameter int                  INSTR_SIZE = 32,
  parameter logic [PC_SIZE-1:0]  ITCM_BASE  = 32'h8000_0000,
  parameter logic [INSTR_SIZE-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  ifu_itcm_ctrl_if.slave     bus,
  output logic               ram_cs,
  output logic               ram_we,
  output logic [ITCM_AW-3:0] ram_addr,
  output logic [3:0]         ram_wem,
`ifdef ITCM_PARITY_EN
  output logic [35:0]        ram_din,
  input  logic [35:0]        ram_dout
`else
  output logic [31:0]        ram_din,
  input  logic [31:0]        ram_dout
`endif
);

  function automatic logic in_range(input logic [PC_SIZE-1:0] a);
    return a[PC_SIZE-1:ITCM_AW] == ITCM_BASE[PC_SIZE-1:ITCM_AW];
  endfunction

  logic                  ld_hit, fe_fire, fe_hit;
  logic                  inflight_vld, inflight_err;
  logic [1:0]            fifo_cnt, credits;
  logic                  fifo_wp, fifo_rp, fifo_empty, fifo_push, fifo_pop;
  logic [INSTR_SIZE-1:0] fifo_instr [2];
  logic [1:0]            fifo_err;
  logic                  bypass_take, rd_err, par_err;
  logic [INSTR_SIZE-1:0] rd_instr;
  logic                  unused_bits;

  assign unused_bits = ^{bus.ifu_req_pc[1:0], bus.ld_addr[1:0]};

  assign fifo_empty  = (fifo_cnt == 2'd0);
  assign bypass_take = fifo_empty & inflight_vld & bus.ifu_rsp_ready;
  // An in-flight read that bypasses straight out this cycle needs no buffer slot.
  assign credits     = fifo_cnt + 2'(inflight_vld & ~bypass_take);

  assign bus.ifu_req_ready = ~bus.ld_valid & (credits < 2'd2);
  assign bus.ld_ready      = 1'b1;

  assign ld_hit  = bus.ld_valid & in_range(bus.ld_addr);
  assign fe_fire = bus.ifu_req_valid & bus.ifu_req_ready;
  assign fe_hit  = fe_fire & in_range(bus.ifu_req_pc);

  assign ram_cs   = ld_hit | fe_hit;
  assign ram_we   = ld_hit;
  assign ram_addr = bus.ld_valid ? bus.ld_addr[ITCM_AW-1:2] : bus.ifu_req_pc[ITCM_AW-1:2];
  assign ram_wem  = bus.ld_wmask;

`ifdef ITCM_PARITY_EN
  logic [3:0] wpar, rpar;
  always_comb begin
    wpar = '0;
    rpar = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      wpar[b] = ^bus.ld_wdata[8*b +: 8];
      rpar[b] = ^ram_dout[8*b +: 8];
    end
  end
  assign ram_din = {wpar, bus.ld_wdata};
  assign par_err = |(rpar ^ ram_dout[35:32]);
`else
  assign ram_din = bus.ld_wdata;
  assign par_err = 1'b0;
`endif

  assign rd_err   = inflight_err | par_err;
  assign rd_instr = rd_err ? NOP_INSTR : INSTR_SIZE'(ram_dout[31:0]);

  assign fifo_push = inflight_vld & ~bypass_take;
  assign fifo_pop  = ~fifo_empty & bus.ifu_rsp_ready;

  always_comb begin
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rsp_instr = '0;
    bus.ifu_rsp_err   = 1'b0;
    if (!fifo_empty) begin
      bus.ifu_rsp_valid = 1'b1;
      bus.ifu_rsp_instr = fifo_instr[fifo_rp];
      bus.ifu_rsp_err   = fifo_err[fifo_rp];
    end else if (inflight_vld) begin
      bus.ifu_rsp_valid = 1'b1;
      bus.ifu_rsp_instr = rd_instr;
      bus.ifu_rsp_err   = rd_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_vld <= 1'b0;
      inflight_err <= 1'b0;
      fifo_cnt     <= '0;
      fifo_wp      <= 1'b0;
      fifo_rp      <= 1'b0;
    end else begin
      inflight_vld <= fe_fire;
      inflight_err <= fe_fire & ~in_range(bus.ifu_req_pc);
      if (fifo_push) fifo_wp <= ~fifo_wp;
      if (fifo_pop)  fifo_rp <= ~fifo_rp;
      fifo_cnt <= fifo_cnt + 2'(fifo_push) - 2'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_instr[fifo_wp] <= rd_instr;
      fifo_err[fifo_wp]   <= rd_err;
    end
  end

endmodule

// File: tb/tb_ifu_itcm_ctrl.sv
// Bench for ifu_itcm_ctrl: directed scenarios then random traffic against a response-queue model.
module tb_ifu_itcm_ctrl;
`ifdef ITCM_PARITY_EN
  localparam int RW = 36;
`else
  localparam int RW = 32;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_itcm_ctrl_if #(.PC_SIZE(32), .INSTR_SIZE(32)) bus ();

  logic          ram_cs, ram_we;
  logic [13:0]   ram_addr;
  logic [3:0]    ram_wem;
  logic [RW-1:0] ram_din, ram_dout;

  ifu_itcm_ctrl #(
    .ITCM_AW(16), .PC_SIZE(32), .INSTR_SIZE(32),
    .ITCM_BASE(32'h8000_0000), .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wem(ram_wem), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // SRAM model with optional read-data corruption
  logic [RW-1:0] sram [0:16383];
  logic [RW-1:0] sram_q = '0;
  logic [RW-1:0] flip_mask = '0;
  assign ram_dout = sram_q;

  always @(posedge clk) begin
    if (ram_cs && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_wem[b]) begin
          sram[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
`ifdef ITCM_PARITY_EN
          sram[ram_addr][32+b] <= ram_din[32+b];
`endif
        end
      end
    end else if (ram_cs) begin
      sram_q <= sram[ram_addr] ^ flip_mask;
    end
  end

  // Reference model
  typedef struct { logic [31:0] instr; logic err; } rsp_t;
  rsp_t        exp_q[$];
  logic [31:0] ref_mem [int unsigned];
  bit          flip_on = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic bit in_range(input logic [31:0] a);
    return (a & ~32'h0000_FFFF) == 32'h8000_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int unsigned k = int'(a[15:2]);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    bus.ifu_req_valid = 1'b0;
    bus.ifu_req_pc    = '0;
    bus.ld_valid      = 1'b0;
    bus.ld_addr       = '0;
    bus.ld_wdata      = '0;
    bus.ld_wmask      = '0;
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic step();
    int unsigned   n;
    bit            exp_ready, ld_hit, fe_hit;
    rsp_t          r;
    logic [31:0]   w;
    logic [RW-1:0] exp_din;
    @(negedge clk);
    n         = exp_q.size();
    exp_ready = !bus.ld_valid && n < 2;
    ld_hit    = bus.ld_valid && in_range(bus.ld_addr);
    fe_hit    = bus.ifu_req_valid && exp_ready && in_range(bus.ifu_req_pc);
    chk("req_ready", bus.ifu_req_ready, exp_ready);
    chk("ld_ready", bus.ld_ready, 1'b1);
    chk("rsp_valid", bus.ifu_rsp_valid, n > 0);
    if (n > 0) begin
      chk("rsp_instr", bus.ifu_rsp_instr, exp_q[0].instr);
      chk("rsp_err", bus.ifu_rsp_err, exp_q[0].err);
    end else begin
      chk("idle_instr", bus.ifu_rsp_instr, 32'h0);
      chk("idle_err", bus.ifu_rsp_err, 1'b0);
    end
    chk("ram_cs", ram_cs, ld_hit || fe_hit);
    chk("ram_we", ram_we, ld_hit);
    if (ld_hit) begin
      exp_din[31:0] = bus.ld_wdata;
`ifdef ITCM_PARITY_EN
      for (int b = 0; b < 4; b++) exp_din[32+b] = ^bus.ld_wdata[8*b +: 8];
`endif
      chk("ld_addr", ram_addr, bus.ld_addr[15:2]);
      chk("ld_wem", ram_wem, bus.ld_wmask);
      chk("ld_din", ram_din, exp_din);
    end
    if (fe_hit) chk("rd_addr", ram_addr, bus.ifu_req_pc[15:2]);
    chk("fifo_ovf", dut.fifo_push && dut.fifo_cnt == 2'd2, 1'b0);

    if (n > 0 && bus.ifu_rsp_ready) void'(exp_q.pop_front());
    if (ld_hit) begin
      w = ref_rd(bus.ld_addr);
      for (int b = 0; b < 4; b++)
        if (bus.ld_wmask[b]) w[8*b +: 8] = bus.ld_wdata[8*b +: 8];
      ref_mem[int'(bus.ld_addr[15:2])] = w;
    end
    if (bus.ifu_req_valid && exp_ready) begin
      if (!in_range(bus.ifu_req_pc) || flip_on) r = '{NOP, 1'b1};
      else                                       r = '{ref_rd(bus.ifu_req_pc), 1'b0};
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    bus.ld_valid = 1'b1; bus.ld_addr = a; bus.ld_wdata = d; bus.ld_wmask = 4'hF;
    step();
    bus.ld_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'h0000_1000 + {$urandom_range(0, 15), 2'b00};
      1:       return 32'h8001_0000;
      2:       return 32'h8000_FFFC;
      default: return 32'h8000_0000 + {$urandom_range(0, 15), 2'(  $urandom_range(0, 3))};
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 16384; i++) sram[i] = '0;
    idle();
    bus.ifu_rsp_ready = 1'b1;

    // reset values
    #12;
    chk("rst_rsp_valid", bus.ifu_rsp_valid, 1'b0);
    chk("rst_rsp_instr", bus.ifu_rsp_instr, 32'h0);
    chk("rst_rsp_err", bus.ifu_rsp_err, 1'b0);
    chk("rst_ram_cs", ram_cs, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_req_ready", bus.ifu_req_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // load then single fetch, 1-cycle latency
    load(32'h8000_0000, 32'h0010_0093);
    load(32'h8000_0004, 32'h1234_5678);
    load(32'h8000_0008, 32'hCAFE_F00D);
    bus.ifu_req_valid = 1'b1; bus.ifu_req_pc = 32'h8000_0000;
    step();
    bus.ifu_req_valid = 1'b0;
    step();

    // back-to-back fetches
    for (int i = 0; i < 3; i++) begin
      bus.ifu_req_valid = 1'b1; bus.ifu_req_pc = 32'h8000_0000 + 32'(4 * i);
      step();
    end
    bus.ifu_req_valid = 1'b0;
    step();

    // stall: only two reads accepted, then drain and resume
    bus.ifu_rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.ifu_req_valid = 1'b1; bus.ifu_req_pc = 32'h8000_0000 + 32'(4 * (i % 3));
      step();
    end
    bus.ifu_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.ifu_req_valid = 1'b0;
    step(); step();

    // out-of-range fetch
    bus.ifu_req_valid = 1'b1; bus.ifu_req_pc = 32'h0000_1000;
    step();
    bus.ifu_req_valid = 1'b0;
    step();

    // load/fetch collision to the same word
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h8000_0010; bus.ld_wdata = 32'hA5A5_0F0F; bus.ld_wmask = 4'hF;
    bus.ifu_req_valid = 1'b1; bus.ifu_req_pc = 32'h8000_0010;
    step();
    bus.ld_valid = 1'b0;
    step();
    bus.ifu_req_valid = 1'b0;
    step();

`ifdef ITCM_PARITY_EN
    // corrupted parity bit on read
    flip_mask = '0; flip_mask[32] = 1'b1; flip_on = 1'b1;
    bus.ifu_req_valid = 1'b1; bus.ifu_req_pc = 32'h8000_0004;
    step();
    flip_mask = '0; flip_on = 1'b0;
    bus.ifu_req_valid = 1'b0;
    step();
`endif

    // reset in the middle of a stall
    bus.ifu_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ifu_req_valid = 1'b1; bus.ifu_req_pc = 32'h8000_0008;
      step();
    end
    bus.ifu_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    chk("midrst_rsp_valid", bus.ifu_rsp_valid, 1'b0);
    chk("midrst_req_ready", bus.ifu_req_ready, 1'b1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.ifu_rsp_ready = 1'b1;
    step();
    bus.ifu_req_valid = 1'b1; bus.ifu_req_pc = 32'h8000_0008;
    step();
    bus.ifu_req_valid = 1'b0;
    step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bus.ld_valid      = ($urandom_range(0, 4) == 0);
      bus.ld_addr       = rand_addr();
      bus.ld_wdata      = $urandom;
      bus.ld_wmask      = 4'($urandom_range(0, 15));
      bus.ifu_req_valid = ($urandom_range(0, 3) != 0);
      bus.ifu_req_pc    = rand_addr();
      bus.ifu_rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    idle();
    bus.ifu_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ifu_itcm_ctrl.md
Name: ifu_itcm_ctrl

Overview:
Instruction TCM controller that sits directly upstream of the fetch stage. It serves that stage's fetch request/response handshake from an external single-port synchronous SRAM. A word-write loader port fills the TCM at boot or from debug. A 2-entry response buffer absorbs response backpressure so that no RAM read is ever lost.

Parameters:
ITCM_AW, 16, byte-address width of the TCM window; RAM depth is 2^(ITCM_AW-2) words
ITCM_BASE, 32'h8000_0000, base address of the TCM window; must be aligned to 2^ITCM_AW
PC_SIZE, 32, PC/address width
INSTR_SIZE, 32, instruction width
NOP_INSTR, 32'h0000_0013, instruction returned on an error response

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ifu_req_valid  in  1  fetch request valid
ifu_req_ready  out  1  fetch request accepted
ifu_req_pc  in  PC_SIZE  fetch address; bits [1:0] ignored
ifu_rsp_valid  out  1  fetch response valid
ifu_rsp_ready  in  1  fetch response accepted
ifu_rsp_instr  out  INSTR_SIZE  fetched instruction
ifu_rsp_err  out  1  response is an error (out of range / parity)
ld_valid  in  1  loader write valid
ld_ready  out  1  loader write accepted; tied to 1
ld_addr  in  PC_SIZE  loader byte address; bits [1:0] ignored
ld_wdata  in  32  loader write data
ld_wmask  in  4  loader byte enables
ram_cs  out  1  SRAM chip select
ram_we  out  1  SRAM write enable
ram_addr  out  ITCM_AW-2  SRAM word address
ram_wem  out  4  SRAM byte write mask
ram_din  out  RW  SRAM write data; RW = 32, or 36 with ITCM_PARITY_EN
ram_dout  in  RW  SRAM read data, valid one cycle after the read cycle

Behaviour:
- Reset: fifo empty, read-in-flight flag 0. Outputs: ifu_rsp_valid=0, ifu_rsp_instr=0, ifu_rsp_err=0, ram_cs=0, ram_we=0, ifu_req_ready=1 (combinational, see below).
- Reset asserted mid-operation: the in-flight read and all buffered responses are discarded.
- In range: a request or load is in range when (addr & ~(2^ITCM_AW-1)) == ITCM_BASE.
- Request acceptance: ifu_req_ready = ~ld_valid & (fifo_cnt + inflight < 2).
  - Load has priority over fetch every cycle.
  - inflight counts only a read that will not be consumed in the current cycle; credit counting guarantees space for every issued read.
- Fetch handshake (req_valid & req_ready) at cycle N:
  - In range: ram_cs=1, ram_we=0, ram_addr=pc[ITCM_AW-1:2]; inflight set with err=0.
  - Out of range: no RAM access; inflight set with err=1.
- Cycle N+1 (read data ready):
  - If fifo empty: bypass. ifu_rsp_valid=1, instr = ram_dout[31:0] (or NOP_INSTR if err), ifu_rsp_err=err.
  - If bypassed but rsp_ready=0, or if fifo not empty: the response is pushed into the fifo.
  - Minimum latency is 1 cycle, with full throughput of 1 fetch/cycle while rsp_ready=1.
- Fifo: 2 entries of {instr, err}, in-order.
  - When non-empty, the head drives the response.
  - Head pops on rsp_valid & rsp_ready.
  - Push and pop in the same cycle leave fifo_cnt unchanged.
  - Writes to a full fifo are impossible by construction; the verification engineer asserts this.
- Loader: ld_valid=1 gives ram_cs=1, ram_we=1, ram_addr=ld_addr word, ram_wem=ld_wmask, ram_din=ld_wdata in the same cycle. Out-of-range loads are dropped with no RAM access.
- Loader/fetch collision: when ld_valid and req_valid are asserted together, the load is written and the fetch stalls with req_ready=0.
- Write followed by read to the same address: the read returns the new data.

Optional Feature:
ITCM_PARITY_EN.
- Defined:
  - RW=36; ram_din[35:32] holds even parity per byte of ld_wdata.
  - On a read, a parity mismatch in any byte whose parity is checked sets err=1 and forces instr=NOP_INSTR.
  - Parity is stored with the byte mask (ram_wem covers each byte and its parity bit).
- Undefined: RW=32, no parity logic, and err comes only from out-of-range accesses.

Test Plan:
- Load 32'h0010_0093 to 0x8000_0000; fetch pc=0x8000_0000 with rsp_ready=1 -> rsp_valid one cycle later, instr=32'h0010_0093, err=0.
- Back-to-back fetches 0x8000_0000/04/08 with rsp_ready=1 -> 3 responses on consecutive cycles, in order.
- rsp_ready=0 with continuous requests -> exactly 2 reads accepted, then req_ready=0. Raise rsp_ready -> both responses drain in order, then fetching resumes.
- Fetch pc=0x0000_1000 -> no ram_cs; response instr=32'h0000_0013, err=1.
- ld_valid and req_valid asserted in the same cycle -> the RAM write occurs and req_ready=0; the fetch is accepted the next cycle and returns the newly written word.
- ITCM_PARITY_EN: force ram_dout[32] flipped -> err=1, instr=NOP; reset asserted mid-stall -> rsp_valid=0 and fifo empty on release.
